// File: rtl/pulse_gen.sv
// pulse_gen: turns single-cycle request strobes into timed output pulses.
// Strobes arriving mid-pulse are queued and replayed back-to-back.
module pulse_gen #(
   parameter int HIGH_CYCLES = 4,
   parameter int LOW_CYCLES  = 2,
   parameter int PEND_W      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in,
   output logic              out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int MAXC = (HIGH_CYCLES > LOW_CYCLES) ?
                         HIGH_CYCLES : LOW_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0]     H_LD  = CW'(HIGH_CYCLES - 1);
   localparam logic [CW-1:0]     L_LD  = CW'(LOW_CYCLES - 1);
   localparam logic [PEND_W-1:0] P_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          sat;
   logic          phase_end;

   // Saturation and phase-end qualifiers for the request bookkeeping
   always_comb begin
      sat       = (pending == P_MAX);
      phase_end = (cnt == '0);
   end

   // Pulse FSM with phase counter, request queue and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         out      <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in) begin
                  state <= HIGH;
                  cnt   <= H_LD;
                  out   <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            HIGH: begin
               if (in) begin
                  if (sat) overflow <= 1'b1;
                  else     pending  <= pending + 1'b1;
               end
               if (phase_end) begin
                  state <= LOW;
                  cnt   <= L_LD;
                  out   <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            LOW: begin
               if (!phase_end) begin
                  cnt <= cnt - 1'b1;
                  if (in) begin
                     if (sat) overflow <= 1'b1;
                     else     pending  <= pending + 1'b1;
                  end
               end else if (in) begin
                  // New request and queue pop cancel out
                  state <= HIGH;
                  cnt   <= H_LD;
                  out   <= 1'b1;
               end else if (pending != '0) begin
                  state   <= HIGH;
                  cnt     <= H_LD;
                  out     <= 1'b1;
                  pending <= pending - 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               out   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: scoreboard bench for pulse_gen.
// An event-level model schedules pulse start times per request.
module tb_pulse_gen;

   localparam int H    = 4;
   localparam int L    = 2;
   localparam int PW   = 3;
   localparam int HL   = H + L;
   localparam int PMAX = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in  = 1'b0;
   logic          out;
   logic          busy;
   logic [PW-1:0] pending;
   logic          overflow;

   pulse_gen #(
      .HIGH_CYCLES(H),
      .LOW_CYCLES (L),
      .PEND_W     (PW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in      (in),
      .out     (out),
      .busy    (busy),
      .pending (pending),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          o;
      logic          b;
      logic [PW-1:0] p;
      logic          ov;
   } exp_t;

   exp_t sbq[$];
   int   starts[$];
   int   last_drop = -100;
   int   cyc       = 0;
   int   acc       = 0;
   int   drops     = 0;
   int   rises     = 0;
   int   ovs       = 0;
   logic prev_out  = 1'b0;
   int   n_chk     = 0;
   int   n_fail    = 0;
   int   r0, a0, d0, v0;

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                tag, cyc, obs, exp);
      end
   endtask

   function automatic void model(bit r, bit i, int t);
      exp_t e;
      int   u;
      int   pc;
      if (r) begin
         starts.delete();
         last_drop = -100;
      end else if (i) begin
         int cur;
         int pend;
         cur  = -1;
         pend = 0;
         foreach (starts[k]) begin
            if (starts[k] <= t && t < starts[k] + HL) cur = starts[k];
            if (starts[k] > t) pend++;
         end
         if (cur < 0) begin
            starts.push_back(t + 1);
            acc++;
         end else if (pend == PMAX && t != cur + HL - 1) begin
            last_drop = t;
            drops++;
         end else begin
            starts.push_back(starts[starts.size() - 1] + HL);
            acc++;
         end
      end
      u    = t + 1;
      e    = '0;
      pc   = 0;
      foreach (starts[k]) begin
         if (starts[k] <= u && u < starts[k] + H)  e.o = 1'b1;
         if (starts[k] <= u && u < starts[k] + HL) e.b = 1'b1;
         if (starts[k] > u) pc++;
      end
      e.p  = PW'(pc);
      e.ov = (last_drop == t);
      sbq.push_back(e);
   endfunction

   task automatic step(input bit r, input bit i);
      exp_t e;
      rst = r;
      in  = i;
      model(r, i, cyc);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      e = sbq.pop_front();
      chk("out", {7'd0, out}, {7'd0, e.o});
      chk("busy", {7'd0, busy}, {7'd0, e.b});
      chk("pending", {5'd0, pending}, {5'd0, e.p});
      chk("overflow", {7'd0, overflow}, {7'd0, e.ov});
      if (out === 1'b1 && prev_out === 1'b0) rises++;
      if (overflow === 1'b1) ovs++;
      prev_out = out;
   endtask

   task automatic mark();
      r0 = rises;
      a0 = acc;
      d0 = drops;
      v0 = ovs;
   endtask

   initial begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);

      // single strobe
      mark();
      step(1'b0, 1'b1);
      repeat (10) step(1'b0, 1'b0);
      chk("t1_pulses", 8'(rises - r0), 8'd1);

      // strobes at relative cycles 0, 2, 3
      mark();
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      repeat (20) step(1'b0, 1'b0);
      chk("t2_pulses", 8'(rises - r0), 8'd3);

      // steady request, saturating the queue
      mark();
      repeat (12) step(1'b0, 1'b1);
      repeat (60) step(1'b0, 1'b0);
      chk("t3_pulses", 8'(rises - r0), 8'(acc - a0));
      chk("t3_ovf", 8'(ovs - v0), 8'(drops - d0));
      chk("t3_total", 8'(rises - r0 + ovs - v0), 8'd12);

      // strobe on the last low cycle with an empty queue
      mark();
      step(1'b0, 1'b1);
      repeat (5) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      repeat (20) step(1'b0, 1'b0);
      chk("t4_pulses", 8'(rises - r0), 8'd2);

      // reset mid-pulse with three requests queued
      mark();
      repeat (4) step(1'b0, 1'b1);
      chk("t5_pend", {5'd0, pending}, 8'd3);
      step(1'b1, 1'b1);
      chk("t5_out", {7'd0, out}, 8'd0);
      chk("t5_busy", {7'd0, busy}, 8'd0);
      repeat (20) step(1'b0, 1'b0);
      chk("t5_pulses", 8'(rises - r0), 8'd1);

      // sparse random strobes, counted as recovered edges
      mark();
      repeat (400) step(1'b0, $urandom_range(0, 9) == 0);
      repeat (60) step(1'b0, 1'b0);
      chk("t6_pulses", 8'(rises - r0), 8'(acc - a0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
